// File: rtl/ram_pkg.sv
// Shared types and sizing constants for the ram_ctrl request/response controller.
package ram_pkg;

    localparam int RAM_DEPTH  = 128;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } ram_ctrl_state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Single-outstanding request controller in front of a synchronous RAM.
// All outputs are registered; next values are formed combinationally from the FSM.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
        return 32'(a) >= 32'(DEPTH);
    endfunction

    ram_ctrl_state_t   state_q, state_d;
    logic              req_we_p0, req_we_d;
    logic              req_ready_d, rsp_valid_d, rsp_err_d;
    logic              ram_cs_d, ram_we_d, ram_oe_d;
    logic [DATA_W-1:0] rsp_rdata_d, ram_wdata_d;
    logic [ADDR_W-1:0] ram_addr_d;

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_p0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_oe_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_we_d = req_we;
                    if (addr_oob(req_addr)) begin
                        // Out-of-range requests never touch the RAM.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ACCESS;
                        ram_cs_d   = 1'b1;
                        ram_addr_d = req_addr;
                        ram_we_d   = req_we;
                        ram_oe_d   = ~req_we;
                        if (req_we) ram_wdata_d = req_wdata;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ACCESS: begin
                if (req_we_p0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // RAM data_out was updated at the ACCESS closing edge.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ram_rdata;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
        endcase
    end

    // Registered outputs and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            ram_cs    <= ram_cs_d;
            ram_we    <= ram_we_d;
            ram_oe    <= ram_oe_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        req_we_p0 <= req_we_d;
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl with a behavioural 128x8 synchronous RAM and a reference memory model.
module tb_ram_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       ram_cs, ram_we, ram_oe;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int discarded = 0;
    time acc_t, prev_t;
    logic prev_cs = 1'b0;

    logic [7:0] ram_mem [0:127];
    logic [7:0] ref_mem [0:127];

    always #5 clk = ~clk;

    ram_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural synchronous RAM: write and registered read on the same edge as the strobes.
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr[6:0]] <= ram_wdata;
        if (ram_cs && ram_oe) ram_rdata <= ram_mem[ram_addr[6:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("we_oe_exclusive", {31'd0, ram_we && ram_oe}, 0);
        chk("cs_single_cycle", {31'd0, prev_cs && ram_cs}, 0);
        chk("strobe_without_cs", {31'd0, (ram_we || ram_oe) && !ram_cs}, 0);
        prev_cs <= ram_cs;
    end

    always @(posedge clk) begin
        if (!reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (!reset && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    // Called at a negedge with the controller idle; returns at a negedge with it idle again.
    task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] wd, input int hold);
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         n;
        exp_err = (addr >= 8'd128);
        if (exp_err) begin
            exp_rd = 8'd0; exp_lat = 1;
        end else if (we) begin
            ref_mem[addr[6:0]] = wd; exp_rd = 8'd0; exp_lat = 2;
        end else begin
            exp_rd = ref_mem[addr[6:0]]; exp_lat = 3;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, n < 20}, 1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 8'd0;
        chk("ready_busy", {31'd0, req_ready}, 0);
        if (exp_err) begin
            chk("err_no_cs", {31'd0, ram_cs}, 0);
        end else begin
            chk("access_cs", {31'd0, ram_cs}, 1);
            chk("access_we", {31'd0, ram_we}, {31'd0, we});
            chk("access_oe", {31'd0, ram_oe}, {31'd0, !we});
            chk("access_addr", {24'd0, ram_addr}, {24'd0, addr});
            chk("access_wdata", {24'd0, ram_wdata}, we ? {24'd0, wd} : 32'd0);
        end
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
            if (exp_err) chk("err_no_cs", {31'd0, ram_cs}, 0);
        end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
        chk("ready_in_resp", {31'd0, req_ready}, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 1);
            chk("hold_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
            chk("hold_ready", {31'd0, req_ready}, 0);
            chk("hold_no_strobe", {29'd0, ram_cs, ram_we, ram_oe}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_valid", {31'd0, rsp_valid}, 0);
        chk("idle_ready", {31'd0, req_ready}, 1);
        chk("idle_rdata", {24'd0, rsp_rdata}, 0);
        chk("idle_err", {31'd0, rsp_err}, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        ram_rdata = 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 8'd0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 1);
        chk("reset_outs", {20'd0, rsp_valid, rsp_err, ram_cs, ram_we, ram_oe, rsp_rdata[0], ram_addr[0],
                           ram_wdata[0], 4'd0}, 0);
        chk("reset_buses", {8'd0, rsp_rdata, ram_addr, ram_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        send(1'b1, 8'h05, 8'hA5, 0);
        send(1'b0, 8'h05, 8'h00, 0);
        send(1'b1, 8'h7F, 8'h3C, 0);
        send(1'b0, 8'h7F, 8'h00, 0);
        send(1'b1, 8'h80, 8'h99, 0);
        send(1'b0, 8'hFF, 8'h00, 0);

        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(8'h10 + i), 0);
        for (int i = 0; i < 4; i++) begin
            prev_t = acc_t;
            send(1'b0, 8'(i), 8'h00, 0);
            if (i > 0) chk("read_throughput", 32'(acc_t - prev_t), 40);
        end

        send(1'b0, 8'h05, 8'h00, 5);

        // Reset asserted while the read sits in CAPTURE.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        discarded++;
        chk("rst_mid_ready", {31'd0, req_ready}, 1);
        chk("rst_mid_outs", {27'd0, rsp_valid, rsp_err, ram_cs, ram_we, ram_oe}, 0);
        chk("rst_mid_rdata", {24'd0, rsp_rdata}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'd0, rsp_valid}, 0);
        end
        send(1'b0, 8'h05, 8'h00, 0);

        for (int i = 0; i < 200; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)), 8'($urandom),
                 int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        chk("one_rsp_per_req", acc_cnt, rsp_cnt + discarded);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
